gate_route_check: RTL and testbench
===================================

// Module: gate_route_check
// PURPOSE
// Parametrised successor to the single-entry receive gate: holds a per-source route-capability table
// written by the host and checks every incoming route request against it before forwarding the port.
// Sits between the network receive path and the user-logic port mux; denied requests are dropped with a
// deny flag and counted, granted requests carry the selected user-logic port.
// PARAMETERS
// N_DESTS   4   number of capability entries (sources); IDX_W = max(1,$clog2(N_DESTS))
// N_PORTS   4   number of user-logic ports; PORT_W = max(1,$clog2(N_PORTS))
// CNT_W     16  width of saturating deny counter
// PORTS
// aclk         in   1        clock
// areset       in   1        asynchronous active-high reset
// cap_we       in   1        host capability write strobe (single cycle, always accepted)
// cap_idx      in   IDX_W    entry to write
// cap_mask     in   N_PORTS  allowed-port bitmask for that entry (bit p = port p permitted)
// cap_clear    in   1        clear all entries to 0 (deny-all)
// req_valid    in   1        route request valid
// req_ready    out  1        route request accepted when valid&ready
// req_src      in   IDX_W    requesting source index
// req_port     in   PORT_W   requested user-logic port
// resp_valid   out  1        lookup result valid
// resp_ready   in   1        downstream accepts result
// resp_port    out  PORT_W   port of the request (echoed)
// resp_grant   out  1        1 = permitted, 0 = denied
// deny_cnt     out  CNT_W    number of denied requests, saturating
// BEHAVIOUR
// - Reset (async assert, sync use after deassert): all table entries 0, resp_valid=0, resp_port=0,
//   resp_grant=0, deny_cnt=0. req_ready is combinational and is 1 while in reset-released idle.
// - Table: N_DESTS x N_PORTS flops. cap_we writes cap_mask into entry cap_idx on the clock edge;
//   cap_idx >= N_DESTS is ignored. cap_clear zeroes every entry; cap_clear and cap_we same cycle:
//   clear wins, write is discarded.
// - Handshake: single output register. req_ready = ~resp_valid | resp_ready. On req_valid&req_ready
//   the result is registered next edge: latency exactly 1 cycle, throughput 1/cycle under resp_ready=1.
//   resp_valid drops only when resp_ready=1 and no new request is accepted. Outputs stay stable while
//   resp_valid=1 and resp_ready=0.
// - Grant rule: grant = (req_src < N_DESTS) & (req_port < N_PORTS) & table[req_src][req_port].
// - Write/lookup same cycle, same entry: lookup uses table value before the write (read-then-write);
//   the new value applies from the next accepted request.
// - deny_cnt increments by 1 on each accepted request with grant=0; holds at 2^CNT_W-1 (no wrap).
//   cap_clear does not reset deny_cnt; only areset does.
// - Reset mid-operation: any in-flight result is lost (resp_valid=0 immediately on areset assert).
// TESTING
// 1 Reset: areset=1 then 0 -> resp_valid=0, deny_cnt=0; request src=0 port=1 -> resp next cycle grant=0, deny_cnt=1.
// 2 Write idx=2 mask=4'b0101; req src=2 port=0 -> grant=1; port=1 -> grant=0; port=2 -> grant=1 (back-to-back, 1/cycle).
// 3 Same-cycle cap_we idx=1 mask=4'b1111 and req src=1 port=3 -> grant=0; next req src=1 port=3 -> grant=1.
// 4 Backpressure: resp_ready=0 with resp_valid=1 -> req_ready=0, resp_port/resp_grant stable 5 cycles;
//   resp_ready=1 -> pending req accepted same cycle, new result next cycle, no loss/duplication.
// 5 cap_clear with cap_we idx=0 mask=4'b0001 same cycle -> req src=0 port=0 grant=0; src=3 out-of-range
//   (N_DESTS=3 build) -> grant=0.
// 6 CNT_W=4: 20 denied requests -> deny_cnt saturates at 15; areset asserted mid-stream -> deny_cnt=0, resp_valid=0.

Source files
------------

// File: rtl/gate_route_check.sv
// -----------------------------------------------------------------------------
// gate_route_check
//
// Per-source route-capability gate. The host fills a table of allowed-port
// bitmasks, one entry per source. Each incoming route request is checked
// against its source's entry. The result is held in a single output register
// with a valid/ready handshake. Denied requests are flagged and counted in a
// saturating counter.
//
// Ports
//   aclk        clock
//   areset      asynchronous active-high reset
//   cap_we      host capability write strobe (one cycle, always accepted)
//   cap_idx     entry to write (values >= N_DESTS are ignored)
//   cap_mask    allowed-port bitmask for the entry (bit p = port p permitted)
//   cap_clear   zero every entry (deny-all); takes priority over cap_we
//   req_valid   route request valid
//   req_ready   route request accepted when req_valid & req_ready
//   req_src     requesting source index
//   req_port    requested user-logic port
//   resp_valid  lookup result valid
//   resp_ready  downstream accepts the result
//   resp_port   echoed port of the request
//   resp_grant  1 = permitted, 0 = denied
//   deny_cnt    saturating count of denied requests (cleared only by areset)
// -----------------------------------------------------------------------------
module gate_route_check #(
  parameter  int N_DESTS = 4,
  parameter  int N_PORTS = 4,
  parameter  int CNT_W   = 16,
  localparam int IDX_W   = (N_DESTS > 1) ? $clog2(N_DESTS) : 1,
  localparam int PORT_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               cap_we,
  input  logic [IDX_W-1:0]   cap_idx,
  input  logic [N_PORTS-1:0] cap_mask,
  input  logic               cap_clear,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [IDX_W-1:0]   req_src,
  input  logic [PORT_W-1:0]  req_port,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [PORT_W-1:0]  resp_port,
  output logic               resp_grant,
  output logic [CNT_W-1:0]   deny_cnt
);

  // capability table
  logic [N_PORTS-1:0] cap_q [N_DESTS];

  // output register and counter
  logic              resp_valid_q, resp_valid_d;
  logic [PORT_W-1:0] resp_port_q,  resp_port_d;
  logic              resp_grant_q, resp_grant_d;
  logic [CNT_W-1:0]  deny_cnt_q,   deny_cnt_d;

  logic               accept;
  logic [N_PORTS-1:0] row;
  logic               lookup_grant;

  assign req_ready = ~resp_valid_q | resp_ready;
  assign accept    = req_valid & req_ready;

  // Row select and bit select are written as compare loops so an
  // out-of-range source or port naturally yields 0 (deny) without ever
  // indexing past the end of the table.
  always_comb begin
    row = '0;
    for (int i = 0; i < N_DESTS; i++) begin
      if (int'(req_src) == i) row = cap_q[i];
    end
  end

  always_comb begin
    lookup_grant = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (int'(req_port) == p) lookup_grant = row[p];
    end
  end

  // Table update. The lookup above reads cap_q before this edge, so a
  // same-cycle write to the requested entry is seen by the next request.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N_DESTS; i++) cap_q[i] <= '0;
    end else if (cap_clear) begin
      for (int i = 0; i < N_DESTS; i++) cap_q[i] <= '0;
    end else if (cap_we) begin
      for (int i = 0; i < N_DESTS; i++) begin
        if (int'(cap_idx) == i) cap_q[i] <= cap_mask;
      end
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_port_d  = resp_port_q;
    resp_grant_d = resp_grant_q;
    deny_cnt_d   = deny_cnt_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_port_d  = req_port;
      resp_grant_d = lookup_grant;
      if (!lookup_grant && (deny_cnt_q != '1)) deny_cnt_d = deny_cnt_q + 1'b1;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= '0;
      resp_grant_q <= 1'b0;
      deny_cnt_q   <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_grant_q <= resp_grant_d;
      deny_cnt_q   <= deny_cnt_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_port  = resp_port_q;
  assign resp_grant = resp_grant_q;
  assign deny_cnt   = deny_cnt_q;

endmodule

// File: tb/tb_gate_route_check.sv
// -----------------------------------------------------------------------------
// tb_gate_route_check
//
// Bench for gate_route_check built with N_DESTS=3 (so source 3 is out of
// range) and CNT_W=4 (so the deny counter saturates quickly). A cycle-level
// reference model (capability array, pending result, deny count) predicts
// every output; directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_gate_route_check;

  localparam int ND     = 3;
  localparam int NP     = 4;
  localparam int CW     = 4;
  localparam int IDX_W  = 2;
  localparam int PORT_W = 2;
  localparam int CMAX   = (1 << CW) - 1;

  logic              aclk = 1'b0;
  logic              areset;
  logic              cap_we;
  logic [IDX_W-1:0]  cap_idx;
  logic [NP-1:0]     cap_mask;
  logic              cap_clear;
  logic              req_valid;
  logic              req_ready;
  logic [IDX_W-1:0]  req_src;
  logic [PORT_W-1:0] req_port;
  logic              resp_valid;
  logic              resp_ready;
  logic [PORT_W-1:0] resp_port;
  logic              resp_grant;
  logic [CW-1:0]     deny_cnt;

  gate_route_check #(.N_DESTS(ND), .N_PORTS(NP), .CNT_W(CW)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .cap_we     (cap_we),
    .cap_idx    (cap_idx),
    .cap_mask   (cap_mask),
    .cap_clear  (cap_clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_port   (req_port),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_port  (resp_port),
    .resp_grant (resp_grant),
    .deny_cnt   (deny_cnt)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [NP-1:0] m_tab [ND];
  bit            m_valid;
  int            m_port;
  bit            m_grant;
  int            m_cnt;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_tab[i] = '0;
    m_valid = 0;
    m_port  = 0;
    m_grant = 0;
    m_cnt   = 0;
  endtask

  // One clock: check ready mid-cycle, advance the model on the edge using
  // the table contents from before any write, then check registered outputs.
  task automatic step();
    bit exp_ready;
    bit g;
    int s, p;
    @(negedge aclk);
    exp_ready = !m_valid || resp_ready;
    check_eq("req_ready", int'(req_ready), int'(exp_ready));
    @(posedge aclk);
    s = int'(req_src);
    p = int'(req_port);
    if (req_valid && exp_ready) begin
      g = 0;
      if (s < ND && p < NP) g = m_tab[s][p];
      m_valid = 1;
      m_port  = p;
      m_grant = g;
      if (!g && m_cnt < CMAX) m_cnt++;
    end else if (resp_ready) begin
      m_valid = 0;
    end
    if (cap_clear) begin
      for (int i = 0; i < ND; i++) m_tab[i] = '0;
    end else if (cap_we && int'(cap_idx) < ND) begin
      m_tab[int'(cap_idx)] = cap_mask;
    end
    #1;
    check_eq("resp_valid", int'(resp_valid), int'(m_valid));
    if (m_valid) begin
      check_eq("resp_port", int'(resp_port), m_port);
      check_eq("resp_grant", int'(resp_grant), int'(m_grant));
    end
    check_eq("deny_cnt", int'(deny_cnt), m_cnt);
  endtask

  task automatic req(input int s, input int p);
    req_valid = 1'b1;
    req_src   = IDX_W'(s);
    req_port  = PORT_W'(p);
  endtask

  initial begin
    int held_port, held_grant;
    areset     = 1'b1;
    cap_we     = 1'b0;
    cap_idx    = '0;
    cap_mask   = '0;
    cap_clear  = 1'b0;
    req_valid  = 1'b0;
    req_src    = '0;
    req_port   = '0;
    resp_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;

    // reset state
    check_eq("rst_resp_valid", int'(resp_valid), 0);
    check_eq("rst_deny_cnt", int'(deny_cnt), 0);
    check_eq("rst_resp_port", int'(resp_port), 0);

    // empty table denies
    req(0, 1);
    step();
    check_eq("t1_grant", int'(resp_grant), 0);
    check_eq("t1_deny", int'(deny_cnt), 1);

    // write entry 2 then back-to-back lookups
    req_valid = 1'b0;
    cap_we = 1'b1; cap_idx = 2'd2; cap_mask = 4'b0101;
    step();
    cap_we = 1'b0;
    req(2, 0); step(); check_eq("t2_p0", int'(resp_grant), 1);
    req(2, 1); step(); check_eq("t2_p1", int'(resp_grant), 0);
    req(2, 2); step(); check_eq("t2_p2", int'(resp_grant), 1);

    // same-cycle write and lookup on the same entry
    cap_we = 1'b1; cap_idx = 2'd1; cap_mask = 4'b1111;
    req(1, 3); step(); check_eq("t3_old", int'(resp_grant), 0);
    cap_we = 1'b0;
    req(1, 3); step(); check_eq("t3_new", int'(resp_grant), 1);

    // backpressure: result held, pending request stalls
    req(2, 0); step();
    resp_ready = 1'b0;
    req(2, 1);
    held_port  = int'(resp_port);
    held_grant = int'(resp_grant);
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("t4_hold_port", int'(resp_port), 0);
      check_eq("t4_hold_grant", int'(resp_grant), 1);
      check_eq("t4_hold_snap", int'(resp_port) * 2 + int'(resp_grant), held_port * 2 + held_grant);
    end
    resp_ready = 1'b1;
    step();
    check_eq("t4_new_port", int'(resp_port), 1);
    check_eq("t4_new_grant", int'(resp_grant), 0);
    req_valid = 1'b0;
    step();
    check_eq("t4_drain", int'(resp_valid), 0);

    // clear beats write; out-of-range source denied
    cap_clear = 1'b1; cap_we = 1'b1; cap_idx = 2'd0; cap_mask = 4'b0001;
    step();
    cap_clear = 1'b0; cap_we = 1'b0;
    req(0, 0); step(); check_eq("t5_clear", int'(resp_grant), 0);
    cap_we = 1'b1; cap_idx = 2'd3; cap_mask = 4'b1111;
    req(3, 0); step(); check_eq("t5_oor_src", int'(resp_grant), 0);
    cap_we = 1'b0;
    req(3, 0); step(); check_eq("t5_oor_src2", int'(resp_grant), 0);

    // saturation
    for (int k = 0; k < 20; k++) begin
      req(3, k % 4);
      step();
    end
    check_eq("t6_sat", int'(deny_cnt), CMAX);

    // async reset mid-stream
    req(0, 2);
    #3 areset = 1'b1;
    #1;
    check_eq("t6_rst_valid", int'(resp_valid), 0);
    check_eq("t6_rst_cnt", int'(deny_cnt), 0);
    model_reset();
    @(posedge aclk);
    #1 areset = 1'b0;
    req_valid = 1'b0;

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      cap_we     = ($urandom_range(0, 3) == 0);
      cap_idx    = IDX_W'($urandom_range(0, 3));
      cap_mask   = NP'($urandom);
      cap_clear  = ($urandom_range(0, 40) == 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_src    = IDX_W'($urandom_range(0, 3));
      req_port   = PORT_W'($urandom_range(0, 3));
      resp_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
